// File: rtl/parity_frame_rx.sv
// Receive-side frame checker: deserialises start/data/parity/stop frames,
// recomputes parity, reports status and keeps a saturating error count.
module parity_frame_rx #(
  parameter int DATA_W = 4,
  parameter bit ODD    = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              par_bad;
  logic              err_any;
  logic              completing;

  // Status of the frame that completes on this edge (rx_in is the stop bit).
  assign par_bad    = par_bit != ((^shift) ^ ODD);
  assign err_any    = par_bad | ~rx_in;
  assign completing = bit_en && (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx_in) begin
              state <= DATA;
              index <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shift[index] <= rx_in;
            index        <= index + 1'b1;
            if (index == IDX_W'(DATA_W - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= rx_in;
            state   <= STOP;
          end
          STOP: begin
            data_out   <= shift;
            parity_err <= par_bad;
            frame_err  <= ~rx_in;
            data_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      // Clear has priority over a coincident increment.
      if (err_clr)
        err_count <= '0;
      else if (completing && err_any && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even-parity DUT plus an odd-parity twin.
module tb_parity_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       rx_in = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
  logic [7:0] err_count;
  logic [3:0] o_data_out;
  logic       o_data_valid, o_parity_err, o_frame_err, o_busy;
  logic [7:0] o_err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(4), .ODD(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  parity_frame_rx #(.DATA_W(4), .ODD(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in), .err_clr(err_clr),
    .data_out(o_data_out), .data_valid(o_data_valid), .parity_err(o_parity_err),
    .frame_err(o_frame_err), .busy(o_busy), .err_count(o_err_count)
  );

  always @(posedge clk) if (data_valid) valid_cnt++;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_bit(input logic b);
    rx_in  = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
  endtask

  // Returns #1 after the edge that sampled the stop bit.
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                            input int gap, input logic clr);
    logic [6:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i == 6) err_clr = clr;
      pulse_bit(bits[i]);
      err_clr = 1'b0;
      if (i < 6) idle(gap - 1);
    end
  endtask

  task automatic test_reset();
    idle(3);
    rst = 1'b0;
    n_cmp++;
    if ({data_out, data_valid, parity_err, frame_err, busy, err_count} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {data_out, data_valid, parity_err, frame_err, busy, err_count});
    end
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = valid_cnt;
    send_frame(4'b1011, 1'b1, 1'b1, 4, 1'b0);
    n_cmp++;
    if ({data_valid, data_out, parity_err, frame_err, err_count} !== {1'b1, 4'b1011, 2'b00, 8'd0}) begin
      n_bad++;
      $display("FAIL good_frame: got v=%b d=%b pe=%b fe=%b cnt=%0d expected v=1 d=1011 pe=0 fe=0 cnt=0",
               data_valid, data_out, parity_err, frame_err, err_count);
    end
    n_cmp++;
    if (o_parity_err !== 1'b1) begin
      n_bad++;
      $display("FAIL odd_parity_err: got %b expected 1", o_parity_err);
    end
    idle(1);
    n_cmp++;
    if (data_valid !== 1'b0 || valid_cnt - v0 != 1) begin
      n_bad++;
      $display("FAIL valid_one_cycle: got v=%b pulses=%0d expected v=0 pulses=1",
               data_valid, valid_cnt - v0);
    end
    n_cmp++;
    if (data_out !== 4'b1011 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_after_done: got d=%b busy=%b expected d=1011 busy=0", data_out, busy);
    end
  endtask

  task automatic test_parity_err();
    send_frame(4'b1011, 1'b0, 1'b1, 4, 1'b0);
    n_cmp++;
    if ({data_valid, data_out, parity_err, frame_err, err_count} !== {1'b1, 4'b1011, 2'b10, 8'd1}) begin
      n_bad++;
      $display("FAIL parity_err: got v=%b d=%b pe=%b fe=%b cnt=%0d expected v=1 d=1011 pe=1 fe=0 cnt=1",
               data_valid, data_out, parity_err, frame_err, err_count);
    end
    idle(3);
  endtask

  task automatic test_frame_err();
    send_frame(4'b0000, 1'b0, 1'b0, 4, 1'b0);
    n_cmp++;
    if ({data_valid, parity_err, frame_err, busy, err_count} !== {1'b1, 2'b01, 1'b0, 8'd2}) begin
      n_bad++;
      $display("FAIL frame_err: got v=%b pe=%b fe=%b busy=%b cnt=%0d expected v=1 pe=0 fe=1 busy=0 cnt=2",
               data_valid, parity_err, frame_err, busy, err_count);
    end
    // Line idles high; a zero stop bit must not look like a start bit.
    idle(8);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_bad_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [3:0] d;
    v0 = valid_cnt;
    for (int v = 0; v < 16; v++) begin
      d = 4'(v);
      send_frame(d, ^d, 1'b1, 1, 1'b0);
      n_cmp++;
      if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, d, 2'b00}) begin
        n_bad++;
        $display("FAIL b2b_frame_%0d: got v=%b d=%h pe=%b fe=%b expected v=1 d=%h pe=0 fe=0",
                 v, data_valid, data_out, parity_err, frame_err, d);
      end
    end
    idle(1);
    n_cmp++;
    if (valid_cnt - v0 != 16 || err_count !== 8'd2) begin
      n_bad++;
      $display("FAIL b2b_totals: got pulses=%0d cnt=%0d expected pulses=16 cnt=2",
               valid_cnt - v0, err_count);
    end
  endtask

  task automatic test_mid_reset();
    int v0;
    v0 = valid_cnt;
    pulse_bit(1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_on_start: got %b expected 1", busy);
    end
    pulse_bit(1'b1);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    rst = 1'b1;
    bit_en = 1'b1;
    err_clr = 1'b1;
    idle(1);
    rst = 1'b0;
    bit_en = 1'b0;
    err_clr = 1'b0;
    n_cmp++;
    if ({data_out, data_valid, parity_err, frame_err, busy, err_count} !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h expected 0000",
               {data_out, data_valid, parity_err, frame_err, busy, err_count});
    end
    idle(4);
    n_cmp++;
    if (valid_cnt != v0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_no_valid: got pulses=%0d busy=%b expected pulses=0 busy=0",
               valid_cnt - v0, busy);
    end
    send_frame(4'b0101, 1'b0, 1'b1, 2, 1'b0);
    n_cmp++;
    if ({data_valid, data_out, parity_err, frame_err, err_count} !== {1'b1, 4'b0101, 2'b00, 8'd0}) begin
      n_bad++;
      $display("FAIL after_reset_frame: got v=%b d=%b pe=%b fe=%b cnt=%0d expected v=1 d=0101 pe=0 fe=0 cnt=0",
               data_valid, data_out, parity_err, frame_err, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 300; i++) begin
      send_frame(4'b0000, 1'b1, 1'b1, 1, 1'b0);
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        n_cmp++;
        if (err_count !== ((i < 255) ? 8'(i) : 8'd255)) begin
          n_bad++;
          $display("FAIL saturate_%0d: got %0d expected %0d", i, err_count,
                   (i < 255) ? i : 255);
        end
      end
    end
    send_frame(4'b0000, 1'b1, 1'b1, 1, 1'b1);
    n_cmp++;
    if ({data_valid, parity_err, err_count} !== {2'b11, 8'd0}) begin
      n_bad++;
      $display("FAIL clear_wins: got v=%b pe=%b cnt=%0d expected v=1 pe=1 cnt=0",
               data_valid, parity_err, err_count);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
